hash_mem_arbiter: RTL and testbench

Round-robin arbiter that shares the single synchronous memory port between NUM_REQ hash engines. Each engine issues word reads (message fetch) and writes (digest store) through a req/gnt handshake. The arbiter registers the winning access onto the memory pins and returns read data to the issuing engine after a fixed latency. It sits between the hash-engine array and the top-level mem_* ports, replacing lock-step broadcast reads when engines run out of phase.

---
 rtl/hash_mem_arbiter_if.sv | 13 +
 rtl/hash_mem_arbiter.sv | 84 ++++++++
 tb/tb_hash_mem_arbiter.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/hash_mem_arbiter_if.sv
// hash_mem_arbiter_if: engine-side bus (master = engines drive req/lock/we/addr/wdata; slave = arbiter drives gnt/rvalid/rdata)
interface hash_mem_arbiter_if #(parameter int NUM_REQ = 4);
  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ-1:0]    lock;
  logic [NUM_REQ-1:0]    we;
  logic [NUM_REQ*16-1:0] addr;
  logic [NUM_REQ*32-1:0] wdata;
  logic [NUM_REQ-1:0]    gnt;
  logic [NUM_REQ-1:0]    rvalid;
  logic [31:0]           rdata;
  modport master (output req, lock, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave (input req, lock, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/hash_mem_arbiter.sv
// hash_mem_arbiter: round-robin arbiter with burst lock sharing one sync memory port (ports: clk, reset_n, eng slave bus, mem_clk/mem_we/mem_addr/mem_write_data out, mem_read_data in)
module hash_mem_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int RD_LAT    = 2,
  parameter int MAX_BURST = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  hash_mem_arbiter_if.slave eng,
  output logic              mem_clk,
  output logic              mem_we,
  output logic [15:0]       mem_addr,
  output logic [31:0]       mem_write_data,
  input  logic [31:0]       mem_read_data
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);
  logic [IW-1:0]     ptr_q, ptr_d, own_q, own_d, rr, win;
  logic              own_v_q, own_v_d, rr_v, hold, win_v, same;
  logic [BW-1:0]     bcnt_q, bcnt_d;
  logic [RD_LAT-1:0] tag_v_q, tag_v_d;
  logic [IW-1:0]     tag_q [RD_LAT];
  logic [IW-1:0]     tag_d [RD_LAT];
  logic              mem_we_q, mem_we_d;
  logic [15:0]       mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wd_q, mem_wd_d;
  always_comb begin
    rr_v = 1'b0;
    rr = ptr_q;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (eng.req[(int'(ptr_q) + k) % NUM_REQ]) begin
        rr_v = 1'b1;
        rr = IW'((int'(ptr_q) + k) % NUM_REQ);
      end
  end
  assign hold  = own_v_q && eng.req[own_q] && eng.lock[own_q] && bcnt_q < BW'(MAX_BURST);
  assign win   = hold ? own_q : rr;
  assign win_v = reset_n && (hold || rr_v);
  assign same  = own_v_q && own_q == win;
  assign eng.gnt = win_v ? NUM_REQ'(1) << win : '0;
  always_comb begin
    ptr_d      = win_v ? (int'(win) == NUM_REQ - 1 ? '0 : win + 1'b1) : ptr_q;
    own_v_d    = win_v && eng.lock[win];
    own_d      = win;
    bcnt_d     = !own_v_d ? '0 : !same ? BW'(1) : bcnt_q == BW'(MAX_BURST) ? bcnt_q : bcnt_q + 1'b1;
    mem_we_d   = win_v && eng.we[win];
    mem_addr_d = win_v ? eng.addr[int'(win)*16 +: 16] : mem_addr_q;
    mem_wd_d   = win_v ? eng.wdata[int'(win)*32 +: 32] : mem_wd_q;
    tag_v_d[0] = win_v && !eng.we[win];
    tag_d[0]   = win;
    for (int k = 1; k < RD_LAT; k++) begin
      tag_v_d[k] = tag_v_q[k-1];
      tag_d[k]   = tag_q[k-1];
    end
  end
  always_ff @(posedge clk)
    if (!reset_n) begin
      ptr_q      <= '0;
      own_v_q    <= 1'b0;
      own_q      <= '0;
      bcnt_q     <= '0;
      tag_v_q    <= '0;
      tag_q      <= '{default: '0};
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_wd_q   <= '0;
    end else begin
      ptr_q      <= ptr_d;
      own_v_q    <= own_v_d;
      own_q      <= own_d;
      bcnt_q     <= bcnt_d;
      tag_v_q    <= tag_v_d;
      tag_q      <= tag_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_wd_q   <= mem_wd_d;
    end
  assign eng.rvalid    = tag_v_q[RD_LAT-1] ? NUM_REQ'(1) << tag_q[RD_LAT-1] : '0;
  assign eng.rdata     = mem_read_data;
  assign mem_clk        = clk;
  assign mem_we         = mem_we_q;
  assign mem_addr       = mem_addr_q;
  assign mem_write_data = mem_wd_q;
endmodule

// File: tb/tb_hash_mem_arbiter.sv
// tb_hash_mem_arbiter: directed plus random bench with a spec-level arbitration and memory model
module tb_hash_mem_arbiter;
  localparam int N = 4, RL = 2, MB = 16;
  logic clk = 1'b0, reset_n = 1'b0;
  logic mem_clk, mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_write_data, mem_read_data;
  logic [31:0] tbmem [0:65535];
  logic [31:0] gold [0:65535];
  int n_cmp = 0, n_bad = 0;
  int m_ptr = 0, m_own = -1, m_cnt = 0, cyc_n = 0, last_w = -1, rv_cnt = 0, g3_cnt = 0, rv0;
  bit m_ok = 1'b0;
  logic e_we = 1'b0;
  logic [15:0] e_addr = '0;
  logic [31:0] e_wd = '0;
  int q_due[$];
  int q_eng[$];
  logic [31:0] q_dat[$];
  int glog[$];
  int gcyc[N];
  int last_rv[N];
  logic [31:0] last_rd[N];
  hash_mem_arbiter_if #(.NUM_REQ(N)) bus();
  hash_mem_arbiter #(.NUM_REQ(N), .RD_LAT(RL), .MAX_BURST(MB)) dut (
    .clk(clk), .reset_n(reset_n), .eng(bus), .mem_clk(mem_clk), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data), .mem_read_data(mem_read_data));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (mem_we) tbmem[mem_addr] <= mem_write_data;
    mem_read_data <= tbmem[mem_addr];
  end
  function automatic logic [31:0] init_word(int a);
    return (32'(a) * 32'h9E3779B1) ^ 32'hA5A50000;
  endfunction
  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic set_eng(int i, bit r, bit l, bit w, logic [15:0] a, logic [31:0] d);
    bus.req[i] = r;
    bus.lock[i] = l;
    bus.we[i] = w;
    bus.addr[16*i +: 16] = a;
    bus.wdata[32*i +: 32] = d;
  endtask
  function automatic int model_win();
    if (!reset_n) return -1;
    if (m_own >= 0 && bus.req[m_own] && bus.lock[m_own] && m_cnt < MB) return m_own;
    for (int k = 0; k < N; k++)
      if (bus.req[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction
  task automatic cyc();
    int w;
    logic [N-1:0] erv;
    logic [31:0] erd;
    logic [15:0] a;
    w = model_win();
    erv = '0;
    erd = '0;
    if (q_due.size() > 0 && q_due[0] == cyc_n) begin
      erv = N'(1) << q_eng[0];
      erd = q_dat[0];
    end
    @(negedge clk);
    chk("gnt", 64'(bus.gnt), w < 0 ? 64'd0 : 64'd1 << w);
    if (m_ok) begin
      chk("mem_we", 64'(mem_we), 64'(e_we));
      chk("mem_addr", 64'(mem_addr), 64'(e_addr));
      chk("mem_wdata", 64'(mem_write_data), 64'(e_wd));
      chk("rvalid", 64'(bus.rvalid), 64'(erv));
      if (erv != '0) chk("rdata", 64'(bus.rdata), 64'(erd));
    end
    for (int i = 0; i < N; i++) begin
      if (bus.gnt[i]) begin
        glog.push_back(i);
        gcyc[i] = cyc_n;
      end
      if (bus.rvalid[i]) begin
        rv_cnt++;
        last_rd[i] = bus.rdata;
        last_rv[i] = cyc_n;
      end
    end
    if (bus.gnt[3]) g3_cnt++;
    @(posedge clk);
    #1;
    if (erv != '0) begin
      void'(q_due.pop_front());
      void'(q_eng.pop_front());
      void'(q_dat.pop_front());
    end
    if (!reset_n) begin
      m_ptr = 0; m_own = -1; m_cnt = 0; m_ok = 1'b1;
      e_we = 1'b0; e_addr = '0; e_wd = '0;
      q_due.delete(); q_eng.delete(); q_dat.delete();
    end else if (w >= 0) begin
      a = bus.addr[16*w +: 16];
      e_we = bus.we[w];
      e_addr = a;
      e_wd = bus.wdata[32*w +: 32];
      if (bus.we[w]) gold[a] = e_wd;
      else begin
        q_due.push_back(cyc_n + RL);
        q_eng.push_back(w);
        q_dat.push_back(gold[a]);
      end
      m_ptr = (w + 1) % N;
      m_cnt = bus.lock[w] ? (m_own == w ? m_cnt + 1 : 1) : 0;
      m_own = bus.lock[w] ? w : -1;
    end else begin
      e_we = 1'b0;
      m_own = -1;
      m_cnt = 0;
    end
    last_w = w;
    cyc_n++;
  endtask
  task automatic idle_all();
    for (int i = 0; i < N; i++) set_eng(i, 0, 0, 0, '0, '0);
  endtask
  task automatic do_reset();
    idle_all();
    reset_n = 1'b0;
    cyc();
    reset_n = 1'b1;
  endtask
  initial begin
    for (int a = 0; a < 65536; a++) begin
      tbmem[a] = init_word(a);
      gold[a] = init_word(a);
    end
    for (int i = 0; i < N; i++) begin
      last_rv[i] = -1;
      gcyc[i] = -1;
      last_rd[i] = '0;
    end
    idle_all();
    reset_n = 1'b0;
    cyc();
    cyc();
    reset_n = 1'b1;
    chk("mem_clk", 64'(mem_clk), 64'd1);
    set_eng(2, 1, 0, 0, 16'h0040, '0);
    cyc();
    set_eng(2, 0, 0, 0, '0, '0);
    for (int k = 0; k < RL + 1; k++) cyc();
    chk("single_rd_lat", 64'(last_rv[2]), 64'(gcyc[2] + RL));
    chk("single_rd_data", 64'(last_rd[2]), 64'(init_word(16'h0040)));
    do_reset();
    glog.delete();
    for (int i = 0; i < N; i++) set_eng(i, 1, 0, 0, 16'(16'h0200 + i), '0);
    for (int k = 0; k < 8; k++) cyc();
    chk("rr_count", 64'(glog.size()), 64'd8);
    for (int k = 0; k < 8 && k < glog.size(); k++) chk("rr_order", 64'(glog[k]), 64'(k % N));
    do_reset();
    glog.delete();
    set_eng(1, 1, 1, 0, 16'h0011, '0);
    set_eng(3, 1, 0, 0, 16'h0013, '0);
    for (int k = 0; k < 20; k++) begin
      cyc();
      if (last_w == 3) set_eng(3, 0, 0, 0, '0, '0);
    end
    chk("burst_count", 64'(glog.size()), 64'd20);
    for (int k = 0; k < 20 && k < glog.size(); k++) chk("burst_order", 64'(glog[k]), k == 16 ? 64'd3 : 64'd1);
    do_reset();
    set_eng(0, 1, 0, 1, 16'h0100, 32'hDEADBEEF);
    set_eng(1, 1, 0, 0, 16'h0100, '0);
    cyc();
    set_eng(0, 0, 0, 0, '0, '0);
    cyc();
    set_eng(1, 0, 0, 0, '0, '0);
    for (int k = 0; k < RL + 1; k++) cyc();
    chk("wr_rd_slot", 64'(gcyc[1]), 64'(gcyc[0] + 1));
    chk("wr_rd_lat", 64'(last_rv[1]), 64'(gcyc[1] + RL));
    chk("wr_rd_data", 64'(last_rd[1]), 64'h0000_0000_DEAD_BEEF);
    rv0 = rv_cnt;
    set_eng(2, 1, 0, 0, 16'h0007, '0);
    cyc();
    set_eng(2, 0, 0, 0, '0, '0);
    reset_n = 1'b0;
    cyc();
    reset_n = 1'b1;
    for (int k = 0; k < RL + 2; k++) cyc();
    chk("rst_drop_rvalid", 64'(rv_cnt), 64'(rv0));
    glog.delete();
    for (int i = 0; i < N; i++) set_eng(i, 1, 0, 0, 16'(16'h0300 + i), '0);
    cyc();
    chk("rst_ptr_count", 64'(glog.size()), 64'd1);
    if (glog.size() > 0) chk("rst_ptr_first", 64'(glog[0]), 64'd0);
    idle_all();
    cyc();
    set_eng(0, 1, 1, 0, 16'h0123, '0);
    cyc();
    g3_cnt = 0;
    set_eng(3, 1, 0, 0, 16'h0033, '0);
    cyc();
    bus.req[3] = 1'b0;
    cyc();
    cyc();
    set_eng(0, 0, 0, 0, '0, '0);
    for (int k = 0; k < 3; k++) cyc();
    chk("withdraw_gnt3", 64'(g3_cnt), 64'd0);
    chk("idle_we", 64'(mem_we), 64'd0);
    chk("idle_addr", 64'(mem_addr), 64'h0123);
    for (int n = 0; n < 3000; n++) begin
      reset_n = ($urandom_range(0, 499) != 0);
      for (int i = 0; i < N; i++)
        if (!bus.req[i] || last_w == i) begin
          if ($urandom_range(0, 2) != 0)
            set_eng(i, 1, $urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)),
                    16'($urandom_range(0, 31)), $urandom);
          else
            set_eng(i, 0, 0, 0, '0, '0);
        end else if ($urandom_range(0, 19) == 0) bus.req[i] = 1'b0;
      cyc();
    end
    reset_n = 1'b1;
    idle_all();
    for (int k = 0; k < RL + 1; k++) cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
